instr_trace_buffer: RTL and testbench
=====================================

INSTR_TRACE_BUFFER -- requirements
Module: instr_trace_buffer

Interface
REQ-001 SHALL have parameter x_cord_width_p, default "inv", tile X coordinate width.
REQ-002 SHALL have parameter y_cord_width_p, default "inv", tile Y coordinate width.
REQ-003 SHALL have parameter els_p, default 8, record-buffer depth, power of 2, >= 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL provide these ports:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- trace_en_i  in  1  capture enable
- stall_all_i, stall_id_i, flush_i  in  1 each  pipeline qualifiers
- is_fp_op_i  in  1  ID-stage instruction is FP
- icache_miss_i  in  1  EXE-next icache miss
- pc_plus4_i  in  32  EXE-next PC+4
- instr_i  in  32  EXE-next instruction
- my_x_i / my_y_i  in  x_cord_width_p / y_cord_width_p  tile coordinates
- tgt_x_i / tgt_y_i  in  x_cord_width_p / y_cord_width_p  tile selected for tracing
- v_o  out  1  head record valid
- pc_o  out  32  head record PC
- instr_o  out  32  head record instruction
- ts_o  out  32  head record timestamp (only with macro, REQ-021)
- yumi_i  in  1  consumer dequeues head
- count_o  out  $clog2(els_p+1)  records held
- drop_count_o  out  16  records lost to overflow

Function
REQ-006 SHALL define capture = trace_en_i & (my_x_i==tgt_x_i) & (my_y_i==tgt_y_i) & ~stall_all_i & ~stall_id_i & ~flush_i & ~is_fp_op_i & ~icache_miss_i & (pc_plus4_i!=0), all sampled at posedge clk_i.
REQ-007 SHALL store record {pc = pc_plus4_i - 4 (mod 2^32), instr = instr_i} on a capture edge.
REQ-008 SHALL be a circular FIFO with els_p entries, separate read/write pointers and explicit occupancy, no lost slot.
REQ-009 SHALL assert v_o iff count_o != 0; pc_o/instr_o SHALL show the oldest record whenever v_o=1.
REQ-010 SHALL have 1-cycle latency: capture at edge N into empty buffer -> v_o=1 after edge N.
REQ-011 SHALL pop on any edge with yumi_i & v_o; yumi_i while v_o=0 SHALL be ignored, state unchanged.
REQ-012 SHALL accept a capture when full if yumi_i & v_o on the same edge; count_o stays els_p.
REQ-013 SHALL drop a capture when full without a same-edge pop; drop_count_o +1, saturating at 16'hFFFF.
REQ-014 SHALL keep count_o unchanged on simultaneous push and pop when not empty.
REQ-015 SHALL wrap read and write pointers from els_p-1 to 0.
REQ-016 SHALL keep draining after trace_en_i falls; only new captures stop.
REQ-017 SHALL never reorder records; dequeue order equals capture order.

Reset
REQ-018 SHALL, while reset_n_i=0, force v_o=0, count_o=0, drop_count_o=0, pointers=0, pc_o/instr_o=0 (ts_o=0 and timestamp counter=0 with macro), regardless of clock.
REQ-019 SHALL discard all buffered records on reset assertion mid-operation; no capture or pop on the edge where reset is released.
REQ-020 SHALL leave record storage contents unreset; they are not observable while v_o=0.

Configuration
REQ-021 SHALL, with INSTR_TRACE_BUFFER_TIMESTAMP_EN defined: keep a free-running 32-bit cycle counter (reset 0, +1 per edge, wraps 32'hFFFFFFFF->0), store its pre-increment value with each record, present it on ts_o.
REQ-022 SHALL, without INSTR_TRACE_BUFFER_TIMESTAMP_EN: omit ts_o port, counter and timestamp storage; all other behaviour identical.

Verification
REQ-023 Single capture: tgt=my coords, trace_en_i=1, pc_plus4_i=32'h0000_1004, instr_i=32'h0000_0013 -> next cycle v_o=1, pc_o=32'h0000_1000, instr_o=32'h0000_0013, count_o=1.
REQ-024 Qualifier masking: repeat REQ-023 once each with stall_all_i, stall_id_i, flush_i, is_fp_op_i, icache_miss_i =1, with pc_plus4_i=0, and with tgt_x_i!=my_x_i -> v_o stays 0, count_o=0.
REQ-025 Overflow: els_p=8, yumi_i=0, 10 consecutive captures -> count_o=8, drop_count_o=2, dequeued PCs = first 8 captured in order.
REQ-026 Full with pop: full buffer, capture and yumi_i=1 same edge -> count_o=8, drop_count_o unchanged, new record becomes tail.
REQ-027 Wrap and reset: 20 captures with yumi_i=1 every cycle -> all 20 dequeued in order, drop_count_o=0; then 3 captures, reset_n_i pulsed low between edges -> v_o=0, count_o=0 immediately.
REQ-028 Timestamp (macro defined): captures at cycles 5 and 9 after reset release -> ts_o reads 5 then 9.

Source files
------------

// File: rtl/instr_trace_buffer.sv
// Instruction trace buffer: captures retiring EXE-next PC/instr pairs for a selected tile
// into a circular FIFO. Define INSTR_TRACE_BUFFER_TIMESTAMP_EN to add a per-record cycle stamp on ts_o.
module instr_trace_buffer #(
  parameter x_cord_width_p = "inv",
  parameter y_cord_width_p = "inv",
  parameter int unsigned els_p = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 trace_en_i,
  input  logic                                 stall_all_i,
  input  logic                                 stall_id_i,
  input  logic                                 flush_i,
  input  logic                                 is_fp_op_i,
  input  logic                                 icache_miss_i,
  input  logic [31:0]                          pc_plus4_i,
  input  logic [31:0]                          instr_i,
  input  logic [x_cord_width_p-1:0]            my_x_i,
  input  logic [y_cord_width_p-1:0]            my_y_i,
  input  logic [x_cord_width_p-1:0]            tgt_x_i,
  input  logic [y_cord_width_p-1:0]            tgt_y_i,
  output logic                                 v_o,
  output logic [31:0]                          pc_o,
  output logic [31:0]                          instr_o,
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
  output logic [31:0]                          ts_o,
`endif
  input  logic                                 yumi_i,
  output logic [$clog2(els_p+1)-1:0]           count_o,
  output logic [15:0]                          drop_count_o
);

  localparam int unsigned PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CNT_W = $clog2(els_p + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;

  logic capture, empty, full, push, pop, drop;

  logic [31:0] pc_mem    [els_p];
  logic [31:0] instr_mem [els_p];

`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] ts_mem [els_p];
`endif

  always_comb begin
    capture = trace_en_i & (my_x_i == tgt_x_i) & (my_y_i == tgt_y_i)
            & ~stall_all_i & ~stall_id_i & ~flush_i & ~is_fp_op_i
            & ~icache_miss_i & (pc_plus4_i != '0);
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(els_p));
    pop     = yumi_i & ~empty;
    // A full buffer still accepts a capture when the head leaves on the same edge.
    push    = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(els_p - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(els_p - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end
  end

`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
  always_comb begin
    ts_d = ts_q + 32'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
      ts_q     <= '0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
      ts_q     <= ts_d;
`endif
    end
  end

  // Storage is deliberately unreset; empty slots are masked at the outputs.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_plus4_i - 32'd4;
      instr_mem[wr_ptr_q] <= instr_i;
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
      ts_mem[wr_ptr_q]    <= ts_q;
`endif
    end
  end

  always_comb begin
    v_o          = ~empty;
    pc_o         = empty ? '0 : pc_mem[rd_ptr_q];
    instr_o      = empty ? '0 : instr_mem[rd_ptr_q];
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
    ts_o         = empty ? '0 : ts_mem[rd_ptr_q];
`endif
    count_o      = count_q;
    drop_count_o = drop_q;
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed self-checking bench for instr_trace_buffer (els_p = 8).
module tb_instr_trace_buffer;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int ELS = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          trace_en = 1'b0;
  logic          stall_all = 1'b0, stall_id = 1'b0, flush = 1'b0;
  logic          is_fp_op = 1'b0, icache_miss = 1'b0;
  logic [31:0]   pc_plus4 = '0, instr = '0;
  logic [XW-1:0] my_x = 4'd3, tgt_x = 4'd3;
  logic [YW-1:0] my_y = 4'd5, tgt_y = 4'd5;
  logic          v;
  logic [31:0]   pc, instr_out;
  logic          yumi = 1'b0;
  logic [3:0]    count;
  logic [15:0]   drop_count;
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
  logic [31:0]   ts;
`endif

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_trace_buffer #(
    .x_cord_width_p(XW),
    .y_cord_width_p(YW),
    .els_p(ELS)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .trace_en_i(trace_en),
    .stall_all_i(stall_all),
    .stall_id_i(stall_id),
    .flush_i(flush),
    .is_fp_op_i(is_fp_op),
    .icache_miss_i(icache_miss),
    .pc_plus4_i(pc_plus4),
    .instr_i(instr),
    .my_x_i(my_x),
    .my_y_i(my_y),
    .tgt_x_i(tgt_x),
    .tgt_y_i(tgt_y),
    .v_o(v),
    .pc_o(pc),
    .instr_o(instr_out),
`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
    .ts_o(ts),
`endif
    .yumi_i(yumi),
    .count_o(count),
    .drop_count_o(drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trace_en = 1'b0; stall_all = 1'b0; stall_id = 1'b0; flush = 1'b0;
    is_fp_op = 1'b0; icache_miss = 1'b0; yumi = 1'b0;
    tgt_x = my_x; tgt_y = my_y;
    pc_plus4 = 32'h0000_1004; instr = 32'h0000_0013;
  endtask

  initial begin
    // Reset state with no clock edge yet
    #2;
    check("rst_v", {31'd0, v}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    step();
    reset_n = 1'b1;

    // Single capture
    idle();
    trace_en = 1'b1;
    step();
    trace_en = 1'b0;
    check("single_v", {31'd0, v}, 32'd1);
    check("single_pc", pc, 32'h0000_1000);
    check("single_instr", instr_out, 32'h0000_0013);
    check("single_count", {28'd0, count}, 32'd1);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    check("single_pop_v", {31'd0, v}, 32'd0);
    check("single_pop_count", {28'd0, count}, 32'd0);

    // Qualifier masking
    for (int i = 0; i < 7; i++) begin
      idle();
      trace_en = 1'b1;
      case (i)
        0: stall_all = 1'b1;
        1: stall_id = 1'b1;
        2: flush = 1'b1;
        3: is_fp_op = 1'b1;
        4: icache_miss = 1'b1;
        5: pc_plus4 = 32'd0;
        default: tgt_x = my_x + 4'd1;
      endcase
      step();
      check($sformatf("mask%0d_v", i), {31'd0, v}, 32'd0);
      check($sformatf("mask%0d_count", i), {28'd0, count}, 32'd0);
    end
    idle();

    // Overflow: 10 captures into 8 slots
    trace_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_plus4 = 32'h0000_2004 + 32'(4 * i);
      instr = 32'h0000_00A0 + 32'(i);
      step();
    end
    trace_en = 1'b0;
    check("ovf_count", {28'd0, count}, 32'd8);
    check("ovf_drop", {16'd0, drop_count}, 32'd2);
    yumi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_pc%0d", i), pc, 32'h0000_2000 + 32'(4 * i));
      check($sformatf("ovf_instr%0d", i), instr_out, 32'h0000_00A0 + 32'(i));
      step();
    end
    yumi = 1'b0;
    check("ovf_empty_v", {31'd0, v}, 32'd0);

    // Full with same-edge pop
    trace_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc_plus4 = 32'h0000_3004 + 32'(4 * i);
      instr = 32'h0000_00B0 + 32'(i);
      step();
    end
    check("full_count", {28'd0, count}, 32'd8);
    pc_plus4 = 32'h0000_4004;
    instr = 32'h0000_00BB;
    yumi = 1'b1;
    step();
    trace_en = 1'b0;
    check("fullpop_count", {28'd0, count}, 32'd8);
    check("fullpop_drop", {16'd0, drop_count}, 32'd2);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("fullpop_pc%0d", i), pc, 32'h0000_3000 + 32'(4 * i));
      step();
    end
    check("fullpop_tail_pc", pc, 32'h0000_4000);
    check("fullpop_tail_instr", instr_out, 32'h0000_00BB);
    step();
    check("fullpop_empty", {28'd0, count}, 32'd0);
    step();
    yumi = 1'b0;
    check("yumi_empty_count", {28'd0, count}, 32'd0);
    check("yumi_empty_drop", {16'd0, drop_count}, 32'd2);

    // Mid-cycle reset clears the drop counter
    #2 reset_n = 1'b0;
    #1 check("rst2_drop", {16'd0, drop_count}, 32'd0);
    step();
    reset_n = 1'b1;

    // Wrap: 20 captures with continuous yumi
    trace_en = 1'b1;
    yumi = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pc_plus4 = 32'h0000_5004 + 32'(4 * k);
      instr = 32'h0000_0C00 + 32'(k);
      if (k > 0) begin
        check($sformatf("wrap_pc%0d", k - 1), pc, 32'h0000_5000 + 32'(4 * (k - 1)));
        check($sformatf("wrap_instr%0d", k - 1), instr_out, 32'h0000_0C00 + 32'(k - 1));
      end
      step();
    end
    trace_en = 1'b0;
    check("wrap_pc19", pc, 32'h0000_504C);
    step();
    yumi = 1'b0;
    check("wrap_count", {28'd0, count}, 32'd0);
    check("wrap_drop", {16'd0, drop_count}, 32'd0);

    // Three captures then reset mid-operation
    trace_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_plus4 = 32'h0000_6004 + 32'(4 * i);
      step();
    end
    check("pre_rst_count", {28'd0, count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_v", {31'd0, v}, 32'd0);
    check("midrst_count", {28'd0, count}, 32'd0);
    check("midrst_pc", pc, 32'd0);
    step();
    check("midrst_hold_count", {28'd0, count}, 32'd0);
    trace_en = 1'b0;
    reset_n = 1'b1;
    check("post_rst_v", {31'd0, v}, 32'd0);

`ifdef INSTR_TRACE_BUFFER_TIMESTAMP_EN
    // Captures on cycles 5 and 9 after reset release
    for (int i = 0; i < 5; i++) step();
    trace_en = 1'b1;
    pc_plus4 = 32'h0000_7004;
    step();
    trace_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    trace_en = 1'b1;
    pc_plus4 = 32'h0000_7008;
    step();
    trace_en = 1'b0;
    check("ts_first", ts, 32'd5);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    check("ts_second", ts, 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
